collection_sweeper: RTL

COLLECTION_SWEEPER -- requirements
Module: collection_sweeper

---
 rtl/collection_sweeper_pkg.sv | 27 ++
 rtl/hyperpipe.sv | 30 +++
 rtl/collection_sweeper.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/collection_sweeper_pkg.sv
// Shared pipeline globals for the collection sweeper.
// Provides the `ADDR_WIDTH / `OUTPUT_READ_LATENCY defaults (overridable
// from the command line), the result-count width and the FSM encoding.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef OUTPUT_READ_LATENCY
`define OUTPUT_READ_LATENCY 3
`endif

package collection_sweeper_pkg;

    localparam int unsigned ADDR_W    = `ADDR_WIDTH;
    localparam int unsigned READ_LAT  = `OUTPUT_READ_LATENCY;
    localparam int unsigned CNT_W     = `ADDR_WIDTH + 3;
    localparam int unsigned DATA_W    = 38;
    localparam int unsigned PCOEFF_W  = 3;
    localparam int unsigned LAT_CNT_W = $clog2(READ_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/hyperpipe.sv
// Generic register pipeline: o_q is i_d delayed by CYCLES clocks.
// Ports: clk, rst (sync, active-high, clears all stages), i_d, o_q.
module hyperpipe #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [CYCLES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < CYCLES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int unsigned i = 1; i < CYCLES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[CYCLES-1];

endmodule

// File: rtl/collection_sweeper.sv
// Collection sweeper: on start, issues every address 0..N-1 to the
// collection stage, accumulates the returned sums (and optionally the
// valid-entry counts) L cycles later, then presents the totals until acked.
// Ports: clk, rst (sync active-high); start / busy handshake; readAddr out;
// summedDataIn / pcoeffCountIn returned data; resultValid / resultAck with
// resultSum and resultPcoeffCount.
// Macro COLLECTION_SWEEPER_PCOEFF_COUNT_EN enables the count accumulator;
// otherwise resultPcoeffCount is tied to zero.
module collection_sweeper
    import collection_sweeper_pkg::*;
#(
    parameter int unsigned SUM_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic [`ADDR_WIDTH-1:0] readAddr,
    input  logic [DATA_W-1:0]      summedDataIn,
    input  logic [PCOEFF_W-1:0]    pcoeffCountIn,
    output logic                   resultValid,
    input  logic                   resultAck,
    output logic [SUM_WIDTH-1:0]   resultSum,
    output logic [CNT_W-1:0]       resultPcoeffCount
);

    sweep_state_e          r_state, w_state_nxt;
    logic [ADDR_W-1:0]     r_addr, w_addr_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_valid, w_valid_nxt;
    logic [LAT_CNT_W-1:0]  r_drain, w_drain_nxt;
    logic [SUM_WIDTH-1:0]  r_sum, w_sum_nxt;
    logic                  w_tag_in;
    logic                  w_tag_out;
    logic                  w_clear;

    // Tags each issued address so only real returns are accumulated.
    hyperpipe #(
        .WIDTH  (1),
        .CYCLES (READ_LAT)
    ) u_valid_pipe (
        .clk (clk),
        .rst (rst),
        .i_d (w_tag_in),
        .o_q (w_tag_out)
    );

    // Next-state, next-output and accumulator update.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = '0;
        w_busy_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
        w_drain_nxt = '0;
        w_tag_in    = 1'b0;
        w_clear     = 1'b0;
        w_sum_nxt   = r_sum;

        if (w_tag_out) begin
            w_sum_nxt = r_sum + SUM_WIDTH'(summedDataIn);
        end

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SWEEP;
                    w_busy_nxt  = 1'b1;
                    w_clear     = 1'b1;
                end
            end
            ST_SWEEP: begin
                w_busy_nxt = 1'b1;
                w_tag_in   = 1'b1;
                if (r_addr == '1) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_addr_nxt = r_addr + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                // The last tag leaves the pipe L cycles after the final address.
                if (r_drain == LAT_CNT_W'(READ_LAT - 1)) begin
                    w_state_nxt = ST_DONE;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_busy_nxt  = 1'b1;
                    w_drain_nxt = r_drain + LAT_CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (resultAck) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_valid_nxt = 1'b1;
                end
            end
        endcase

        if (w_clear) begin
            w_sum_nxt = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_drain <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_busy  <= w_busy_nxt;
            r_valid <= w_valid_nxt;
            r_drain <= w_drain_nxt;
            r_sum   <= w_sum_nxt;
        end
    end

`ifdef COLLECTION_SWEEPER_PCOEFF_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Valid-entry count accumulator, cleared on sweep start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_clear) begin
            r_cnt <= '0;
        end else if (w_tag_out) begin
            r_cnt <= r_cnt + CNT_W'(pcoeffCountIn);
        end
    end

    assign resultPcoeffCount = r_cnt;
`else
    logic w_unused_pcoeff;
    assign w_unused_pcoeff   = ^pcoeffCountIn;
    assign resultPcoeffCount = '0;
`endif

    assign busy        = r_busy;
    assign readAddr    = r_addr;
    assign resultValid = r_valid;
    assign resultSum   = r_sum;

endmodule
